// File: rtl/qoi_chunk_decoder_pkg.sv
// Shared types, opcode constants, FSM encoding and the colour-index hash
// used by the QOI chunk decoder and its index table.
package qoi_chunk_decoder_pkg;

  // Pixel layout keeps r in the least significant byte so RGB output is a plain truncation
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  typedef logic [5:0]  index_t;
  typedef logic [29:0] size_t;

  // Decoder FSM encoding
  typedef logic [2:0] dec_state_t;
  localparam dec_state_t ST_IDLE    = 3'd0;
  localparam dec_state_t ST_OP      = 3'd1;
  localparam dec_state_t ST_PAYLOAD = 3'd2;
  localparam dec_state_t ST_EMIT    = 3'd3;
  localparam dec_state_t ST_DONE    = 3'd4;

  // Chunk tags; the two 8-bit tags share the 2-bit RUN prefix and are checked first
  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
  localparam logic [7:0] QOI_MASK_2   = 8'hC0;

  // Every image starts from opaque black
  localparam pixel_t START_PIXEL = 32'hFF00_0000;

  // Colour-index slot of a pixel: (r*3 + g*5 + b*7 + a*11) mod 64 on full RGBA
  function automatic index_t qoi_hash(input pixel_t p);
    logic [15:0] sum;
    sum = 16'(p.r) * 16'd3 + 16'(p.g) * 16'd5 + 16'(p.b) * 16'd7 + 16'(p.a) * 16'd11;
    return sum[5:0];
  endfunction

endpackage

// File: rtl/qoi_chunk_decoder_index_table.sv
// 64-entry colour index: register array with per-entry valid bits so the
// whole table can be invalidated in one cycle. Invalid entries read as zero.
module qoi_index_table
  import qoi_chunk_decoder_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear_all,
  input  index_t rd_addr,
  output pixel_t rd_data,
  input  logic   wr_en,
  input  index_t wr_addr,
  input  pixel_t wr_data
);

  pixel_t      entries [64];
  logic [63:0] valid;

  // Entry storage; contents are meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  // Valid bits: reset and clear_all invalidate everything, a write validates its slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  assign rd_data = valid[rd_addr] ? entries[rd_addr] : '0;

endmodule

// File: rtl/qoi_chunk_decoder.sv
// QOI chunk decoder: turns the post-header QOI byte stream into pixels, one
// per cycle at best, tracking previous pixel, colour index and run length.
module qoi_chunk_decoder
  import qoi_chunk_decoder_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_pixels,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*CHANNELS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  dec_state_t       state;
  pixel_t           cur_pix;
  pixel_t           prev;
  logic [CNT_W-1:0] remaining;
  logic [5:0]       run_cnt;
  logic [7:0]       op_byte;
  logic [1:0]       pay_idx;

  pixel_t     idx_rd_data;
  logic       idx_clear;
  logic       fire;

  pixel_t     dec_pix;
  dec_state_t dec_state;
  logic [5:0] dec_run;

  pixel_t     pay_pix;
  logic       pay_last;
  logic [7:0] luma_dg;

  assign in_ready  = (state == ST_OP) || (state == ST_PAYLOAD);
  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && (remaining == CNT_W'(1));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_data  = cur_pix[8*CHANNELS-1:0];
  assign fire      = out_valid && out_ready;
  assign idx_clear = (state == ST_IDLE) && start;

  qoi_index_table u_index (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (idx_clear),
    .rd_addr   (in_data[5:0]),
    .rd_data   (idx_rd_data),
    .wr_en     (fire),
    .wr_addr   (qoi_hash(cur_pix)),
    .wr_data   (cur_pix)
  );

  // Decode a chunk tag byte into the next pixel, next state and run length
  always_comb begin
    dec_pix   = prev;
    dec_state = ST_EMIT;
    dec_run   = 6'd1;
    if (in_data == QOI_OP_RGB || in_data == QOI_OP_RGBA) begin
      dec_state = ST_PAYLOAD;
    end else begin
      case (in_data & QOI_MASK_2)
        QOI_OP_INDEX: dec_pix = idx_rd_data;
        QOI_OP_DIFF: begin
          dec_pix.r = prev.r + {6'd0, in_data[5:4]} - 8'd2;
          dec_pix.g = prev.g + {6'd0, in_data[3:2]} - 8'd2;
          dec_pix.b = prev.b + {6'd0, in_data[1:0]} - 8'd2;
        end
        QOI_OP_LUMA: dec_state = ST_PAYLOAD;
        default: dec_run = in_data[5:0] + 6'd1;
      endcase
    end
  end

  // Fold one payload byte into the pixel under construction
  always_comb begin
    pay_pix  = cur_pix;
    pay_last = 1'b0;
    luma_dg  = {2'b00, op_byte[5:0]} - 8'd32;
    if ((op_byte & QOI_MASK_2) == QOI_OP_LUMA) begin
      pay_pix.r = prev.r + luma_dg + {4'd0, in_data[7:4]} - 8'd8;
      pay_pix.g = prev.g + luma_dg;
      pay_pix.b = prev.b + luma_dg + {4'd0, in_data[3:0]} - 8'd8;
      pay_pix.a = prev.a;
      pay_last  = 1'b1;
    end else begin
      case (pay_idx)
        2'd0: pay_pix.r = in_data;
        2'd1: pay_pix.g = in_data;
        2'd2: begin
          pay_pix.b = in_data;
          pay_last  = (op_byte == QOI_OP_RGB);
        end
        default: begin
          pay_pix.a = in_data;
          pay_last  = 1'b1;
        end
      endcase
    end
  end

  // Main sequencer: image start, byte intake, pixel emission and completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_pix   <= '0;
      prev      <= '0;
      remaining <= '0;
      run_cnt   <= '0;
      op_byte   <= '0;
      pay_idx   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= num_pixels;
            prev      <= START_PIXEL;
            err       <= 1'b0;
            state     <= (num_pixels == '0) ? ST_DONE : ST_OP;
          end
        end
        ST_OP: begin
          if (in_valid) begin
            cur_pix <= dec_pix;
            run_cnt <= dec_run;
            op_byte <= in_data;
            pay_idx <= 2'd0;
            state   <= dec_state;
          end
        end
        ST_PAYLOAD: begin
          if (in_valid) begin
            cur_pix <= pay_pix;
            pay_idx <= pay_idx + 2'd1;
            if (pay_last) begin
              state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            prev      <= cur_pix;
            remaining <= remaining - CNT_W'(1);
            run_cnt   <= run_cnt - 6'd1;
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
              if (run_cnt != 6'd1) begin
                err <= 1'b1;
              end
            end else if (run_cnt == 6'd1) begin
              state <= ST_OP;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
